gshare_pht: RTL and testbench

GSHARE_PHT -- requirements
Module: gshare_pht

---
 rtl/gshare_pht.sv | 177 +++++++++++++++++
 tb/tb_gshare_pht.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_pht.sv
// ============================================================================
// Module   : gshare_pht
// Brief    : Gshare pattern history table with speculative global history,
//            mispredict recovery and a power-on INIT sweep of all counters.
//            Optional same-cycle update bypass: define GSHARE_PHT_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gshare_pht #(
    parameter int S_INDEX = 4,
    parameter int CTR_W   = 3,
    parameter int HIST_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               ready_o,
    input  logic               pred_valid_i,
    input  logic [S_INDEX-1:0] pred_pc_i,
    output logic               pred_taken_o,
    output logic [S_INDEX-1:0] pred_idx_o,
    output logic [HIST_W-1:0]  pred_hist_o,
    input  logic               upd_valid_i,
    input  logic [S_INDEX-1:0] upd_idx_i,
    input  logic               upd_taken_i,
    input  logic               upd_mispredict_i,
    input  logic [HIST_W-1:0]  upd_hist_i
);

    localparam int unsigned        DEPTH    = 2 ** S_INDEX;
    localparam logic [0:0]         ST_INIT  = 1'b0;
    localparam logic [0:0]         ST_READY = 1'b1;
    localparam logic [CTR_W-1:0]   CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]   CTR_MIN  = '0;
    localparam logic [S_INDEX-1:0] PTR_LAST = '1;

    logic [0:0]         state_q, state_d;
    logic [S_INDEX-1:0] ptr_q, ptr_d;
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic               sync_q;

    logic [CTR_W-1:0]   ctr_mem [DEPTH];

    logic [S_INDEX-1:0] ghr_ext;
    logic [S_INDEX-1:0] lookup_idx;
    logic [CTR_W-1:0]   rd_ctr;
    logic [CTR_W-1:0]   upd_old;
    logic [CTR_W-1:0]   upd_new;
    logic [CTR_W-1:0]   taken_ctr;
    logic               ready;
    logic               mem_we;
    logic [S_INDEX-1:0] mem_waddr;
    logic [CTR_W-1:0]   mem_wdata;
    logic [HIST_W-1:0]  spec_hist;
    logic [HIST_W-1:0]  rec_hist;

    // Release synchroniser: the sweep starts one edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                if (sync_q) begin
                    ptr_d = ptr_q + S_INDEX'(1);
                    if (ptr_q == PTR_LAST) begin
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    // The sweep and resolved updates share the single table write port.
    always_comb begin
        ready     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = upd_idx_i;
        mem_wdata = upd_new;
        case (state_q)
            ST_INIT: begin
                mem_we    = sync_q;
                mem_waddr = ptr_q;
                mem_wdata = CTR_WEAK;
            end
            ST_READY: begin
                ready  = 1'b1;
                mem_we = upd_valid_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            ctr_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        ghr_ext               = '0;
        ghr_ext[HIST_W-1:0]   = ghr_q;
    end

    assign lookup_idx = pred_pc_i ^ ghr_ext;
    assign rd_ctr     = ctr_mem[lookup_idx];
    assign upd_old    = ctr_mem[upd_idx_i];

    always_comb begin
        if (upd_taken_i) begin
            upd_new = (upd_old == CTR_MAX) ? upd_old : upd_old + CTR_W'(1);
        end else begin
            upd_new = (upd_old == CTR_MIN) ? upd_old : upd_old - CTR_W'(1);
        end
    end

    always_comb begin
        taken_ctr = rd_ctr;
`ifdef GSHARE_PHT_BYPASS_EN
        if (ready && upd_valid_i && (upd_idx_i == lookup_idx)) begin
            taken_ctr = upd_new;
        end
`endif
    end

    assign ready_o      = ready;
    assign pred_taken_o = ready & taken_ctr[CTR_W-1];
    assign pred_idx_o   = lookup_idx;
    assign pred_hist_o  = ghr_q;

    generate
        if (HIST_W == 1) begin : g_hist_single
            assign spec_hist = pred_taken_o;
            assign rec_hist  = upd_taken_i;
        end else begin : g_hist_multi
            assign spec_hist = {ghr_q[HIST_W-2:0], pred_taken_o};
            assign rec_hist  = {upd_hist_i[HIST_W-2:0], upd_taken_i};
        end
    endgenerate

    // Mispredict recovery wins over a same-cycle speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (ready) begin
            if (upd_valid_i && upd_mispredict_i) begin
                ghr_d = rec_hist;
            end else if (pred_valid_i) begin
                ghr_d = spec_hist;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gshare_pht.sv
// ============================================================================
// Module   : tb_gshare_pht
// Brief    : Self-checking bench for gshare_pht against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gshare_pht;

    localparam int S     = 4;
    localparam int C     = 3;
    localparam int H     = 4;
    localparam int DEPTH = 16;
    localparam int HALF  = 4;
    localparam int CMAX  = 7;
    localparam int HMASK = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ready;
    logic         pred_valid;
    logic [S-1:0] pred_pc;
    logic         pred_taken;
    logic [S-1:0] pred_idx;
    logic [H-1:0] pred_hist;
    logic         upd_valid;
    logic [S-1:0] upd_idx;
    logic         upd_taken;
    logic         upd_mispredict;
    logic [H-1:0] upd_hist;

    gshare_pht #(.S_INDEX(S), .CTR_W(C), .HIST_W(H)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ready_o          (ready),
        .pred_valid_i     (pred_valid),
        .pred_pc_i        (pred_pc),
        .pred_taken_o     (pred_taken),
        .pred_idx_o       (pred_idx),
        .pred_hist_o      (pred_hist),
        .upd_valid_i      (upd_valid),
        .upd_idx_i        (upd_idx),
        .upd_taken_i      (upd_taken),
        .upd_mispredict_i (upd_mispredict),
        .upd_hist_i       (upd_hist)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int m_ctr [DEPTH];
    int m_ghr;
    bit m_ready;
    int m_edges;

    function automatic int sat_step(int v, bit up);
        int r;
        r = up ? v + 1 : v - 1;
        if (r > CMAX) r = CMAX;
        if (r < 0)    r = 0;
        return r;
    endfunction

    function automatic bit exp_taken();
        int idx;
        int v;
        if (!m_ready) return 1'b0;
        idx = int'(pred_pc) ^ m_ghr;
        v   = m_ctr[idx];
`ifdef GSHARE_PHT_BYPASS_EN
        if (upd_valid && int'(upd_idx) == idx) v = sat_step(v, upd_taken);
`endif
        return v >= HALF;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_ghr   = 0;
        m_edges = 0;
    endtask

    // Model advance for one rising edge, using the inputs held across it.
    task automatic model_edge();
        bit t;
        if (!rst_n) return;
        if (!m_ready) begin
            m_edges++;
            if (m_edges == DEPTH + 1) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_ctr[i] = HALF;
            end
            return;
        end
        t = exp_taken();
        if (upd_valid) m_ctr[upd_idx] = sat_step(m_ctr[upd_idx], upd_taken);
        if (upd_valid && upd_mispredict)
            m_ghr = ((int'(upd_hist) << 1) | int'(upd_taken)) & HMASK;
        else if (pred_valid)
            m_ghr = ((m_ghr << 1) | int'(t)) & HMASK;
    endtask

    always @(negedge clk) begin
        #1;
        check("ready", int'(ready), int'(m_ready));
        check("pred_idx", int'(pred_idx), int'(pred_pc) ^ m_ghr);
        check("pred_hist", int'(pred_hist), m_ghr);
        check("pred_taken", int'(pred_taken), int'(exp_taken()));
    end

    task automatic idle();
        pred_valid     = 1'b0;
        pred_pc        = '0;
        upd_valid      = 1'b0;
        upd_idx        = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        upd_hist       = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic release_and_sweep(input string name);
        rst_n   = 1'b1;
        m_edges = 0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            tick();
            check(name, int'(ready), int'(k == DEPTH + 1));
        end
    endtask

    task automatic probe(input string name, input int idx, input int exp);
        idle();
        pred_pc = S'(idx ^ m_ghr);
        #2;
        check(name, int'(pred_taken), exp);
        tick();
    endtask

    task automatic upd5(input bit up, input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            pred_pc   = S'(5 ^ m_ghr);
            upd_valid = 1'b1;
            upd_idx   = S'(5);
            upd_taken = up;
            tick();
        end
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            pred_valid     = 1'($urandom_range(0, 1));
            pred_pc        = S'($urandom_range(0, DEPTH - 1));
            upd_valid      = 1'($urandom_range(0, 1));
            upd_idx        = ($urandom_range(0, 2) == 0) ? S'(int'(pred_pc) ^ m_ghr)
                                                         : S'($urandom_range(0, DEPTH - 1));
            upd_taken      = 1'($urandom_range(0, 1));
            upd_mispredict = ($urandom_range(0, 3) == 0);
            upd_hist       = H'($urandom_range(0, HMASK));
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        #2;
        check("rst_ready", int'(ready), 0);
        check("rst_hist", int'(pred_hist), 0);
        pred_pc = S'(9);
        #1;
        check("rst_idx_eq_pc", int'(pred_idx), 9);
        @(negedge clk);
        idle();
        release_and_sweep("sweep_ready");

        // Same-cycle lookup and decrement of index 7 at weakly taken.
        idle();
        pred_pc   = S'(7);
        upd_valid = 1'b1;
        upd_idx   = S'(7);
        upd_taken = 1'b0;
        #2;
`ifdef GSHARE_PHT_BYPASS_EN
        check("bypass_idx7", int'(pred_taken), 0);
`else
        check("bypass_idx7", int'(pred_taken), 1);
`endif
        tick();
        probe("idx7_after_dec", 7, 0);

        // History shift: pc 3 with GHR 0 then pc 3 with GHR 1.
        idle();
        pred_valid = 1'b1;
        pred_pc    = S'(3);
        #2;
        check("lookup1_idx", int'(pred_idx), 3);
        check("lookup1_taken", int'(pred_taken), 1);
        check("lookup1_hist", int'(pred_hist), 0);
        tick();
        pred_valid = 1'b1;
        pred_pc    = S'(3);
        #2;
        check("lookup2_idx", int'(pred_idx), 2);
        check("lookup2_hist", int'(pred_hist), 1);
        tick();

        // Saturation of index 5 at both ends.
        upd5(1'b1, 5);
        probe("sat_hi_5inc", 5, 1);
        upd5(1'b0, 3);
        probe("sat_hi_3dec", 5, 1);
        upd5(1'b0, 1);
        probe("sat_hi_4dec", 5, 0);
        upd5(1'b0, 4);
        probe("sat_lo_8dec", 5, 0);
        upd5(1'b1, 3);
        probe("sat_lo_3inc", 5, 0);
        upd5(1'b1, 1);
        probe("sat_lo_4inc", 5, 1);

        // Recovery overrides a same-cycle speculative shift.
        idle();
        pred_valid     = 1'b1;
        pred_pc        = S'(11);
        upd_valid      = 1'b1;
        upd_idx        = S'(0);
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        upd_hist       = 4'b1010;
        tick();
        idle();
        #2;
        check("recover_hist", int'(pred_hist), 5);
        tick();

        random_cycles(3000);

        // Reset in the middle of the sweep, at pointer 9.
        idle();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n   = 1'b1;
        m_edges = 0;
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("midsweep_async_ready", int'(ready), 0);
        tick();
        release_and_sweep("resweep_ready");
        probe("resweep_idx7", 7, 1);
        probe("resweep_idx5", 5, 1);

        random_cycles(1000);

        // Reset during normal operation.
        idle();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("op_async_ready", int'(ready), 0);
        check("op_async_hist", int'(pred_hist), 0);
        @(negedge clk);
        tick();
        release_and_sweep("opreset_ready");
        random_cycles(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
